// File: rtl/mcu_pkg.sv
// Shared command codes, header bytes and channel state encoding for the
// rocstar clock-counter emulation.
package mcu_pkg;

    localparam logic [3:0] CMD_NOP  = 4'h0;
    localparam logic [3:0] CMD_CLR  = 4'h1;
    localparam logic [3:0] CMD_SNAP = 4'h2;
    localparam logic [3:0] CMD_PING = 4'h3;

    localparam logic [7:0] HDR_SNAP = 8'hA5;
    localparam logic [7:0] HDR_PING = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } chan_state_e;

    function automatic logic [7:0] ping_byte(input logic [5:0] chan_id);
        ping_byte = HDR_PING | {2'b00, chan_id};
    endfunction

endpackage

// File: rtl/rocstar_clkcnt_emu_chan.sv
// One emulated rocstar clock counter: free-running counter, edge-detected
// command pipeline and the byte-serial response FSM.
module rocstar_chan
    import mcu_pkg::*;
#(
    parameter int W       = 48,
    parameter int CHAN_ID = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   cmd_i,
    output logic [7:0]   data_o,
    output logic [W-1:0] cnt_o,
    output logic         busy_o,
    output logic         ovr_o
);

    localparam int              NB      = W / 8;
    localparam int              IW      = $clog2(NB + 1);
    localparam logic [IW-1:0]   IDX_TOP = IW'(NB - 1);
    localparam logic [5:0]      ID6     = 6'(CHAN_ID);

    logic [3:0]    cmd_q;
    logic [3:0]    cmd_qq;
    logic [W-1:0]  cnt_q;
    logic [W-1:0]  snap_q;
    logic [7:0]    data_q;
    logic          busy_q;
    logic          ovr_q;
    logic          ping_q;
    logic [IW-1:0] idx_q;
    chan_state_e   state_q;

    logic          fire;
    logic          is_clr;
    logic          is_burst;
    logic [IW-1:0] idx_m1;
    logic [7:0]    byte_cur;
    logic [7:0]    byte_nxt;

    // A command only fires when the line rises out of NOP.
    assign fire     = (cmd_q != CMD_NOP) && (cmd_qq == CMD_NOP);
    assign is_clr   = fire && (cmd_q == CMD_CLR);
    assign is_burst = fire && ((cmd_q == CMD_SNAP) || (cmd_q == CMD_PING));
    assign idx_m1   = idx_q - IW'(1);
    assign byte_cur = 8'(snap_q >> (8 * idx_q));
    assign byte_nxt = 8'(snap_q >> (8 * idx_m1));

    // Counter, command pipeline and response FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= 4'h0;
            cmd_qq  <= 4'h0;
            cnt_q   <= '0;
            snap_q  <= '0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ping_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            cmd_q  <= cmd_i;
            cmd_qq <= cmd_q;

            if (is_clr) begin
                cnt_q <= '0;
                ovr_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + W'(1);
                if (is_burst && (state_q != ST_IDLE)) begin
                    ovr_q <= 1'b1;
                end else begin
                    ovr_q <= ovr_q;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (fire && (cmd_q == CMD_SNAP)) begin
                        snap_q  <= cnt_q;
                        data_q  <= HDR_SNAP;
                        busy_q  <= 1'b1;
                        ping_q  <= 1'b0;
                        idx_q   <= IDX_TOP;
                        state_q <= ST_HDR;
                    end else if (fire && (cmd_q == CMD_PING)) begin
                        data_q  <= ping_byte(ID6);
                        busy_q  <= 1'b1;
                        ping_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end else begin
                        data_q  <= 8'h00;
                        busy_q  <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (ping_q) begin
                        data_q  <= 8'h00;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        data_q  <= byte_cur;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (idx_q == '0) begin
                        data_q  <= 8'h00;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        data_q  <= byte_nxt;
                        idx_q   <= idx_m1;
                    end
                end
                default: begin
                    data_q  <= 8'h00;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/rocstar_clkcnt_emu.sv
// N independent rocstar clock-counter channels; pure port slicing around
// one rocstar_chan per channel.
module rocstar_clkcnt_emu
    import mcu_pkg::*;
#(
    parameter int NCHAN = 8,
    parameter int W     = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NCHAN-1:0]   cmd_in,
    output logic [8*NCHAN-1:0]   data_out,
    output logic [W*NCHAN-1:0]   cnt,
    output logic [NCHAN-1:0]     busy,
    output logic [NCHAN-1:0]     ovr
);

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        rocstar_chan #(
            .W       (W),
            .CHAN_ID (c)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .cmd_i  (cmd_in[4*c +: 4]),
            .data_o (data_out[8*c +: 8]),
            .cnt_o  (cnt[W*c +: W]),
            .busy_o (busy[c]),
            .ovr_o  (ovr[c])
        );
    end

endmodule

// File: tb/tb_rocstar_clkcnt_emu.sv
// Directed bench for rocstar_clkcnt_emu: a W=48 eight-channel instance and a
// W=8 two-channel instance sharing clock and reset.
module tb_rocstar_clkcnt_emu;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cmd_in;
    logic [63:0]  data_out;
    logic [383:0] cnt;
    logic [7:0]   busy;
    logic [7:0]   ovr;

    logic [7:0]   cmd8;
    logic [15:0]  data8;
    logic [15:0]  cnt8;
    logic [1:0]   busy8;
    logic [1:0]   ovr8;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_cnt [8];
    logic [7:0]  exp8;
    logic [47:0] snapv;
    int          busy_cycles;

    always #5 clk = ~clk;

    rocstar_clkcnt_emu #(.NCHAN(8), .W(48)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_in   (cmd_in),
        .data_out (data_out),
        .cnt      (cnt),
        .busy     (busy),
        .ovr      (ovr)
    );

    rocstar_clkcnt_emu #(.NCHAN(2), .W(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_in   (cmd8),
        .data_out (data8),
        .cnt      (cnt8),
        .busy     (busy8),
        .ovr      (ovr8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and keep the free-running counter model in step.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int c = 0; c < 8; c++) exp_cnt[c] = exp_cnt[c] + 48'd1;
            exp8 = exp8 + 8'd1;
        end
    endtask

    function automatic logic [7:0] lane(input int c);
        lane = data_out[8*c +: 8];
    endfunction

    function automatic logic [47:0] cnt_of(input int c);
        cnt_of = cnt[48*c +: 48];
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        cmd_in = 32'h0;
        cmd8   = 8'h0;
        exp8   = 8'h00;
        for (int c = 0; c < 8; c++) exp_cnt[c] = 48'd0;

        // 1: reset state, then first count
        repeat (5) tick();
        check_eq("rst_data", data_out, 64'h0);
        check_eq("rst_cnt_lo", cnt[63:0], 64'h0);
        check_eq("rst_cnt_hi", cnt[383:320], 64'h0);
        check_eq("rst_busy", {56'h0, busy}, 64'h0);
        check_eq("rst_ovr", {56'h0, ovr}, 64'h0);
        check_eq("rst_w8", {32'h0, data8, cnt8}, 64'h0);
        rst_n = 1'b1;
        tick();
        check_eq("cnt0_first", {16'h0, cnt_of(0)}, 64'd1);

        // 2: SNAP on channel 2
        cmd_in[11:8] = 4'h2;
        tick();
        snapv = exp_cnt[2];
        cmd_in[11:8] = 4'h0;
        tick();
        check_eq("snap2_hdr", {56'h0, lane(2)}, 64'hA5);
        check_eq("snap2_busy_hdr", {63'h0, busy[2]}, 64'd1);
        for (int k = 5; k >= 0; k--) begin
            tick();
            check_eq($sformatf("snap2_byte%0d", k), {56'h0, lane(2)}, {56'h0, snapv[8*k +: 8]});
            check_eq($sformatf("snap2_busy%0d", k), {63'h0, busy[2]}, 64'd1);
        end
        tick();
        check_eq("snap2_tail", {56'h0, lane(2)}, 64'h0);
        check_eq("snap2_busy_end", {63'h0, busy[2]}, 64'd0);
        check_eq("cnt2_run", {16'h0, cnt_of(2)}, {16'h0, exp_cnt[2]});

        // 3: CLR channel 5 when it reaches 1000
        for (int i = 0; i < 2000 && exp_cnt[5] != 48'd999; i++) tick();
        cmd_in[23:20] = 4'h1;
        tick();
        check_eq("cnt5_pre", {16'h0, cnt_of(5)}, 64'd1000);
        cmd_in[23:20] = 4'h0;
        tick();
        exp_cnt[5] = 48'd0;
        check_eq("cnt5_clr", {16'h0, cnt_of(5)}, 64'd0);
        check_eq("cnt4_keep", {16'h0, cnt_of(4)}, {16'h0, exp_cnt[4]});
        tick();
        check_eq("cnt5_one", {16'h0, cnt_of(5)}, 64'd1);
        check_eq("cnt6_keep", {16'h0, cnt_of(6)}, {16'h0, exp_cnt[6]});

        // 4: W=8 wrap and SNAP at 255
        for (int i = 0; i < 300 && exp8 != 8'd254; i++) tick();
        cmd8[3:0] = 4'h2;
        tick();
        check_eq("w8_at255", {48'h0, cnt8[7:0]}, 64'hFF);
        cmd8[3:0] = 4'h0;
        tick();
        check_eq("w8_wrap0", {48'h0, cnt8[7:0]}, 64'h0);
        check_eq("w8_hdr", {56'h0, data8[7:0]}, 64'hA5);
        tick();
        check_eq("w8_wrap1", {48'h0, cnt8[7:0]}, 64'h1);
        check_eq("w8_byte", {56'h0, data8[7:0]}, 64'hFF);
        check_eq("w8_busy", {63'h0, busy8[0]}, 64'd1);
        tick();
        check_eq("w8_tail", {56'h0, data8[7:0]}, 64'h0);
        check_eq("w8_busy_end", {63'h0, busy8[0]}, 64'd0);

        // 5: PING during SNAP burst on channel 0 is dropped and flagged
        cmd_in[3:0] = 4'h2;
        tick();
        snapv = exp_cnt[0];
        cmd_in[3:0] = 4'h0;
        tick();
        check_eq("ovr_hdr", {56'h0, lane(0)}, 64'hA5);
        cmd_in[3:0] = 4'h3;
        tick();
        check_eq("ovr_b5", {56'h0, lane(0)}, {56'h0, snapv[47:40]});
        cmd_in[3:0] = 4'h0;
        tick();
        check_eq("ovr_set", {63'h0, ovr[0]}, 64'd1);
        check_eq("ovr_b4", {56'h0, lane(0)}, {56'h0, snapv[39:32]});
        for (int k = 3; k >= 0; k--) begin
            tick();
            check_eq($sformatf("ovr_b%0d", k), {56'h0, lane(0)}, {56'h0, snapv[8*k +: 8]});
        end
        tick();
        check_eq("ovr_tail", {56'h0, lane(0)}, 64'h0);
        check_eq("ovr_others", {56'h0, ovr}, 64'h01);
        cmd_in[3:0] = 4'h1;
        tick();
        cmd_in[3:0] = 4'h0;
        tick();
        exp_cnt[0] = 48'd0;
        check_eq("ovr_clr", {63'h0, ovr[0]}, 64'd0);
        check_eq("cnt0_clr", {16'h0, cnt_of(0)}, 64'd0);

        // 6a: held SNAP nibble gives exactly one burst
        busy_cycles = 0;
        cmd_in[7:4] = 4'h2;
        repeat (20) begin
            tick();
            if (busy[1]) busy_cycles++;
        end
        cmd_in[7:4] = 4'h0;
        repeat (6) begin
            tick();
            if (busy[1]) busy_cycles++;
        end
        check_eq("hold_busy_cycles", 64'(busy_cycles), 64'd7);

        // 6b: PING on every channel at once
        cmd_in = 32'h3333_3333;
        tick();
        cmd_in = 32'h0;
        tick();
        check_eq("ping_all", data_out, 64'hC7C6_C5C4_C3C2_C1C0);
        check_eq("ping_busy", {56'h0, busy}, 64'hFF);
        check_eq("ping_ovr", {56'h0, ovr}, 64'h0);
        tick();
        check_eq("ping_tail", data_out, 64'h0);
        check_eq("ping_busy_end", {56'h0, busy}, 64'h0);

        // 6c: reset in the middle of a SNAP burst
        cmd_in[15:12] = 4'h2;
        tick();
        cmd_in[15:12] = 4'h0;
        tick();
        check_eq("midrst_hdr", {56'h0, lane(3)}, 64'hA5);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_data", data_out, 64'h0);
        check_eq("midrst_busy", {56'h0, busy}, 64'h0);
        check_eq("midrst_cnt", cnt[63:0], 64'h0);
        check_eq("midrst_w8", {32'h0, data8, cnt8}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
